// File: rtl/bus_controller.sv
// Bus controller for a snooping cache: serialises one coherence request at a time
// through optional write-back, snoop broadcast and memory fill, with a wait timeout.
module bus_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        writeMiss,
    input  logic        readMiss,
    input  logic        writeBack,
    input  logic        invalidate,
    input  logic [7:0]  addr,
    input  logic [15:0] wbData,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        bus_valid,
    output logic [1:0]  bus_op,
    output logic [7:0]  bus_addr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic        fill_valid,
    output logic [15:0] fill_data,
    output logic        timeout,
    output logic        req_drop,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WB    = 3'd1,
        S_BCAST = 3'd2,
        S_FILL  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WR   = 2'b10;
    localparam logic [1:0] OP_INV  = 2'b11;

    state_e      state_q, state_d;
    logic        ret_q, ret_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  lat_addr_q, lat_addr_d;
    logic [15:0] lat_wbd_q, lat_wbd_d;
    logic [1:0]  lat_op_q, lat_op_d;
    logic        lat_wb_q, lat_wb_d;

    logic        busy_q, busy_d;
    logic        bus_valid_q, bus_valid_d;
    logic [1:0]  bus_op_q, bus_op_d;
    logic [7:0]  bus_addr_q, bus_addr_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        fill_valid_q, fill_valid_d;
    logic [15:0] fill_data_q, fill_data_d;
    logic        timeout_q, timeout_d;
    logic        req_drop_q, req_drop_d;

    logic        any_req;
    logic        miss;
    logic [1:0]  req_op;
    logic [8:0]  cnt_inc;
    logic        timed_out;
    logic        abort;

    assign any_req   = writeMiss | readMiss | writeBack | invalidate;
    assign miss      = writeMiss | readMiss;
    assign req_op    = writeMiss ? OP_WR : (readMiss ? OP_RD : (invalidate ? OP_INV : OP_NONE));
    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    // The wait window is exactly TIMEOUT cycles; a ready in the last one still completes.
    assign timed_out = !mem_ready && (cnt_inc == 9'(TIMEOUT));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lat_addr_d  = lat_addr_q;
        lat_wbd_d   = lat_wbd_q;
        lat_op_d    = lat_op_q;
        lat_wb_d    = lat_wb_q;
        fill_data_d = fill_data_q;
        abort       = 1'b0;

        case (state_q)
            S_IDLE: begin
                // ret_q blanks sampling for the first cycle back in IDLE
                if (!ret_q && any_req) begin
                    lat_addr_d = addr;
                    lat_wbd_d  = wbData;
                    lat_op_d   = req_op;
                    lat_wb_d   = writeBack & miss;
                    if (req_op != OP_NONE) begin
                        cnt_d   = 8'd0;
                        state_d = lat_wb_d ? S_WB : S_BCAST;
                    end
                end
            end
            S_WB: begin
                if (mem_ready) begin
                    state_d = S_BCAST;
                end else if (timed_out) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            S_BCAST: begin
                if (lat_op_q == OP_INV) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ready) begin
                    fill_data_d = mem_rdata;
                    state_d     = S_DONE;
                end else if (timed_out) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so every port comes straight off a flop.
        ret_d        = (state_q != S_IDLE) && (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        bus_valid_d  = (state_d == S_BCAST);
        bus_op_d     = bus_valid_d ? lat_op_d : 2'b00;
        bus_addr_d   = bus_valid_d ? lat_addr_d : 8'd0;
        mem_req_d    = (state_d == S_WB) || (state_d == S_FILL);
        mem_we_d     = (state_d == S_WB);
        mem_addr_d   = mem_req_d ? lat_addr_d : 8'd0;
        mem_wdata_d  = mem_we_d ? lat_wbd_d : 16'd0;
        fill_valid_d = (state_d == S_DONE);
        timeout_d    = abort;
        req_drop_d   = req_drop_q | (busy_q & any_req);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            ret_q        <= 1'b0;
            cnt_q        <= 8'd0;
            lat_addr_q   <= 8'd0;
            lat_wbd_q    <= 16'd0;
            lat_op_q     <= 2'b00;
            lat_wb_q     <= 1'b0;
            busy_q       <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_op_q     <= 2'b00;
            bus_addr_q   <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 8'd0;
            mem_wdata_q  <= 16'd0;
            fill_valid_q <= 1'b0;
            fill_data_q  <= 16'd0;
            timeout_q    <= 1'b0;
            req_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            cnt_q        <= cnt_d;
            lat_addr_q   <= lat_addr_d;
            lat_wbd_q    <= lat_wbd_d;
            lat_op_q     <= lat_op_d;
            lat_wb_q     <= lat_wb_d;
            busy_q       <= busy_d;
            bus_valid_q  <= bus_valid_d;
            bus_op_q     <= bus_op_d;
            bus_addr_q   <= bus_addr_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            fill_valid_q <= fill_valid_d;
            fill_data_q  <= fill_data_d;
            timeout_q    <= timeout_d;
            req_drop_q   <= req_drop_d;
        end
    end

    assign busy       = busy_q;
    assign bus_valid  = bus_valid_q;
    assign bus_op     = bus_op_q;
    assign bus_addr   = bus_addr_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fill_valid = fill_valid_q;
    assign fill_data  = fill_data_q;
    assign timeout    = timeout_q;
    assign req_drop   = req_drop_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bus_controller.sv
// Bench for bus_controller: a transaction-level model expands each request into the
// cycle-by-cycle output trace it must produce; one negedge process compares every cycle.
module tb_bus_controller;

    localparam int TMO = 15;
    localparam int W   = 57;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        writeMiss = 1'b0, readMiss = 1'b0, writeBack = 1'b0, invalidate = 1'b0;
    logic [7:0]  addr = 8'd0;
    logic [15:0] wbData = 16'd0;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic        busy, bus_valid, mem_req, mem_we, fill_valid, timeout, req_drop;
    logic [1:0]  bus_op;
    logic [7:0]  bus_addr, mem_addr;
    logic [15:0] mem_wdata, fill_data;
    logic [2:0]  dbg_state;

    always #5 clock = ~clock;

    bus_controller #(.TIMEOUT(TMO)) dut (
        .clock(clock), .resetn(resetn),
        .writeMiss(writeMiss), .readMiss(readMiss), .writeBack(writeBack), .invalidate(invalidate),
        .addr(addr), .wbData(wbData), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy(busy), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .fill_valid(fill_valid), .fill_data(fill_data), .timeout(timeout), .req_drop(req_drop),
        .dbg_state(dbg_state)
    );

    logic [W-1:0] act_w;
    assign act_w = {busy, bus_valid, bus_op, bus_addr, mem_req, mem_we, mem_addr, mem_wdata,
                    fill_valid, fill_data, timeout, req_drop};

    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;
    int errors = 0, checks = 0, cyc = 0, nb = 0;
    logic [15:0] fill_m = 16'd0;
    logic        drop_m = 1'b0;

    // Event monitor used by the literal latency/count checks.
    int t_bv = 0, t_fv = 0, t_req = 0, t_to = 0, t_we = 0;
    int we_cnt = 0, bv_cnt = 0, fv_cnt = 0, req_cnt = 0, to_cnt = 0;
    logic mreq_prev = 1'b0;

    always @(negedge clock) begin
        cyc++;
        if (bus_valid) begin t_bv = cyc; bv_cnt++; end
        if (fill_valid) begin t_fv = cyc; fv_cnt++; end
        if (mem_req && !mreq_prev) t_req = cyc;
        if (mem_req) req_cnt++;
        if (mem_we) begin t_we = cyc; we_cnt++; end
        if (timeout) begin t_to = cyc; to_cnt++; end
        mreq_prev = mem_req;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act_w !== e) begin
                errors++;
                $display("FAIL trace cyc=%0d got=%h exp=%h", cyc, act_w, e);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic bsy, input logic bv, input logic [1:0] op,
                                        input logic [7:0] ba, input logic mr, input logic mw,
                                        input logic [7:0] ma, input logic [15:0] md,
                                        input logic fv, input logic to);
        return {bsy, bv, op, ba, mr, mw, ma, md, fv, fill_m, to, drop_m};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        writeMiss  = 1'b0;
        readMiss   = 1'b0;
        writeBack  = 1'b0;
        invalidate = 1'b0;
        mem_ready  = 1'b0;
        mem_rdata  = 16'($urandom);
    endtask

    // One busy cycle; optionally fires a stray request that must only set req_drop.
    task automatic bstep(input int drop_at, input logic [W-1:0] ev);
        step();
        exp_q.push_back(ev);
        nb++;
        if (nb == drop_at) begin
            readMiss = 1'b1;
            drop_m   = 1'b1;
        end
    endtask

    // lat < 0 means memory never answers in that phase.
    task automatic txn(input bit wm, input bit rm, input bit wbk, input bit inv,
                       input logic [7:0] a, input logic [15:0] wd, input int wb_lat,
                       input int fill_lat, input logic [15:0] rd, input int drop_at,
                       input bit ret_strobe);
        bit miss, do_wb, abort_m;
        logic [1:0] op;
        miss  = wm | rm;
        op    = wm ? 2'b10 : (rm ? 2'b01 : (inv ? 2'b11 : 2'b00));
        do_wb = wbk & miss;
        abort_m = 1'b0;
        nb = 0;
        step();
        exp_q.push_back(mk(0, 0, 2'b00, 8'd0, 0, 0, 8'd0, 16'd0, 0, 0));
        writeMiss = wm; readMiss = rm; writeBack = wbk; invalidate = inv;
        addr = a; wbData = wd;
        if (op != 2'b00) begin
            if (do_wb) begin
                for (int j = 0; ; j++) begin
                    bstep(drop_at, mk(1, 0, 2'b00, 8'd0, 1, 1, a, wd, 0, 0));
                    if (j == wb_lat) begin mem_ready = 1'b1; break; end
                    if (j + 1 == TMO) begin abort_m = 1'b1; break; end
                end
            end
            if (!abort_m) begin
                bstep(drop_at, mk(1, 1, op, a, 0, 0, 8'd0, 16'd0, 0, 0));
                mem_ready = 1'b1;
                if (op != 2'b11) begin
                    for (int j = 0; ; j++) begin
                        bstep(drop_at, mk(1, 0, 2'b00, 8'd0, 1, 0, a, 16'd0, 0, 0));
                        if (j == fill_lat) begin
                            mem_ready = 1'b1; mem_rdata = rd; fill_m = rd;
                            break;
                        end
                        if (j + 1 == TMO) begin abort_m = 1'b1; break; end
                    end
                    if (!abort_m) begin
                        bstep(drop_at, mk(1, 0, 2'b00, 8'd0, 0, 0, 8'd0, 16'd0, 1, 0));
                        mem_ready = 1'b1;
                    end
                end
            end
            step();
            exp_q.push_back(mk(0, 0, 2'b00, 8'd0, 0, 0, 8'd0, 16'd0, 0, abort_m));
            if (ret_strobe) begin readMiss = 1'b1; addr = 8'hAA; end
        end
        step();
        exp_q.push_back(mk(0, 0, 2'b00, 8'd0, 0, 0, 8'd0, 16'd0, 0, 0));
    endtask

    int we0, bv0, fv0, req0, to0;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs", 32'(act_w == '0), 32'd1);
        resetn = 1'b1;

        // Plain read miss, memory answers on the first fill cycle.
        we0 = we_cnt; fv0 = fv_cnt;
        txn(0, 1, 0, 0, 8'h3C, 16'd0, -1, 0, 16'hBEEF, 0, 0);
        chk("read_bv_to_fv", 32'(t_fv - t_bv), 32'd2);
        chk("read_fill_data", 32'(fill_data), 32'hBEEF);
        chk("read_no_write", 32'(we_cnt - we0), 32'd0);
        chk("read_one_fill", 32'(fv_cnt - fv0), 32'd1);

        // Write miss with dirty victim: write-back finishes before the broadcast.
        we0 = we_cnt;
        txn(1, 0, 1, 0, 8'h10, 16'h1234, 2, 1, 16'hCAFE, 0, 0);
        chk("wb_write_cycles", 32'(we_cnt - we0), 32'd3);
        chk("wb_before_bcast", 32'(t_bv - t_we), 32'd1);

        // Invalidate: one broadcast, no memory traffic.
        bv0 = bv_cnt; fv0 = fv_cnt; req0 = req_cnt;
        txn(0, 0, 0, 1, 8'h7F, 16'd0, -1, -1, 16'd0, 0, 0);
        chk("inv_one_bcast", 32'(bv_cnt - bv0), 32'd1);
        chk("inv_no_mem", 32'(req_cnt - req0), 32'd0);
        chk("inv_no_fill", 32'(fv_cnt - fv0), 32'd0);

        // writeBack alone is not a request.
        txn(0, 0, 1, 0, 8'h44, 16'h9999, -1, -1, 16'd0, 0, 0);
        // Priority and invalidate-with-miss suppression, return-cycle strobe ignored.
        txn(1, 1, 0, 1, 8'h22, 16'h0, -1, 3, 16'h5A5A, 0, 1);
        txn(0, 1, 0, 1, 8'h81, 16'h0, -1, 2, 16'h0F0F, 0, 0);
        txn(0, 1, 1, 1, 8'h90, 16'h7777, 0, 0, 16'h1111, 0, 1);
        chk("no_drop_yet", 32'(req_drop), 32'd0);

        // Fill timeout: abort after exactly TMO waiting cycles.
        fv0 = fv_cnt; to0 = to_cnt;
        txn(0, 1, 0, 0, 8'hE1, 16'd0, -1, -1, 16'd0, 0, 0);
        chk("fill_timeout_lat", 32'(t_to - t_req), 32'd15);
        chk("fill_timeout_once", 32'(to_cnt - to0), 32'd1);
        chk("fill_timeout_nofill", 32'(fv_cnt - fv0), 32'd0);
        // Write-back timeout aborts before any broadcast.
        bv0 = bv_cnt;
        txn(1, 0, 1, 0, 8'hE2, 16'hDEAD, -1, 0, 16'd0, 0, 0);
        chk("wb_timeout_nobcast", 32'(bv_cnt - bv0), 32'd0);
        // Ready on the last cycle of the window still completes.
        to0 = to_cnt;
        txn(0, 1, 0, 0, 8'hE3, 16'd0, -1, TMO - 1, 16'h4242, 0, 0);
        txn(1, 0, 1, 0, 8'hE4, 16'h3030, TMO - 1, 0, 16'h2424, 0, 0);
        chk("late_ready_no_timeout", 32'(to_cnt - to0), 32'd0);
        chk("late_ready_data", 32'(fill_data), 32'h2424);

        // Request during FILL is dropped; in-flight fill completes.
        fv0 = fv_cnt;
        txn(0, 1, 0, 0, 8'h66, 16'd0, -1, 4, 16'hABCD, 2, 0);
        chk("drop_sticky", 32'(req_drop), 32'd1);
        chk("drop_fill_done", 32'(fv_cnt - fv0), 32'd1);
        txn(0, 1, 0, 0, 8'h67, 16'd0, -1, 1, 16'h6767, 0, 0);

        // Reset in the middle of a write-back.
        step();
        exp_q.push_back(mk(0, 0, 2'b00, 8'd0, 0, 0, 8'd0, 16'd0, 0, 0));
        writeMiss = 1'b1; writeBack = 1'b1; addr = 8'h55; wbData = 16'hA5A5;
        step();
        exp_q.push_back(mk(1, 0, 2'b00, 8'd0, 1, 1, 8'h55, 16'hA5A5, 0, 0));
        step();
        exp_q.push_back(mk(1, 0, 2'b00, 8'd0, 1, 1, 8'h55, 16'hA5A5, 0, 0));
        step();
        resetn = 1'b0;
        #1;
        chk("reset_mid_wb", 32'(act_w == '0), 32'd1);
        fill_m = 16'd0;
        drop_m = 1'b0;
        bv0 = bv_cnt; fv0 = fv_cnt; to0 = to_cnt;
        step();
        step();
        resetn = 1'b1;
        chk("reset_no_pulses", 32'((bv_cnt - bv0) + (fv_cnt - fv0) + (to_cnt - to0)), 32'd0);
        txn(0, 1, 0, 0, 8'h3C, 16'd0, -1, 0, 16'hBEEF, 0, 0);
        chk("post_reset_fill", 32'(fill_data), 32'hBEEF);
        chk("post_reset_drop", 32'(req_drop), 32'd0);

        step();
        step();
        chk("trace_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
